// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle instruction sequencer.
// Walks FETCH/DECODE/EXECUTE/MEMORY/WB/PCUPD with one-hot stage enables,
// bounds the data-memory wait, and holds the architectural PC.
// Optional build macro SEQ_CTRL_PERF_EN enables the cycle/instruction
// performance counters; without it both counter ports read constant 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a start pulse
// FETCH   | opcode sampled and latched; fetch faults / halt detected
// DECODE  | one-cycle decode stage
// EXECUTE | one-cycle execute; picks MEMORY or WB from the latched opcode
// MEMORY  | dmem_req held high until ack, data fault or wait timeout
// WB      | one-cycle write-back stage
// PCUPD   | pc <= new_pc, then back to FETCH
// HALT    | absorbing, stat=HLT
// ERROR   | absorbing, stat=ADR or INS

module seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        imem_error,
    input  logic        dmem_ack,
    input  logic        dmem_error,
    input  logic [63:0] new_pc,
    output logic [63:0] pc,
    output logic        en_fetch,
    output logic        en_decode,
    output logic        en_execute,
    output logic        en_memory,
    output logic        en_wb,
    output logic        en_pc,
    output logic        dmem_req,
    output logic [1:0]  stat,
    output logic        halted,
    output logic        busy,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    // A timeout of 0 still needs a one-bit counter.
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WB,
        S_PCUPD,
        S_HALT,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        stat_next;
    logic [3:0]        icode_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              needs_mem;

    // Opcodes that touch data memory.
    always_comb begin
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: needs_mem = 1'b1;
            default:                            needs_mem = 1'b0;
        endcase
    end

    // State and status register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            stat  <= STAT_AOK;
        end else begin
            state <= state_next;
            stat  <= stat_next;
        end
    end

    // Next-state and status decode; fetch faults take priority over halt.
    always_comb begin
        state_next = state;
        stat_next  = stat;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_next = S_ERROR;
                    stat_next  = STAT_ADR;
                end else if (icode == 4'h0) begin
                    state_next = S_HALT;
                    stat_next  = STAT_HLT;
                end else if (icode > 4'hB) begin
                    state_next = S_ERROR;
                    stat_next  = STAT_INS;
                end else begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = needs_mem ? S_MEMORY : S_WB;
            S_MEMORY: begin
                if (dmem_ack) begin
                    if (dmem_error) begin
                        state_next = S_ERROR;
                        stat_next  = STAT_ADR;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_ERROR;
                    stat_next  = STAT_ADR;
                end
            end
            S_WB:    state_next = S_PCUPD;
            S_PCUPD: state_next = S_FETCH;
            default: state_next = state;
        endcase
    end

    // Opcode latch, PC register and MEMORY wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icode_q  <= 4'h0;
            pc       <= RESET_PC;
            wait_cnt <= '0;
        end else begin
            if (state == S_FETCH) icode_q <= icode;
            if (state == S_PCUPD) pc <= new_pc;
            if (state == S_MEMORY && state_next == S_MEMORY)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // Stage enables and status flags decoded from the current state.
    always_comb begin
        en_fetch   = (state == S_FETCH);
        en_decode  = (state == S_DECODE);
        en_execute = (state == S_EXECUTE);
        en_memory  = (state == S_MEMORY);
        en_wb      = (state == S_WB);
        en_pc      = (state == S_PCUPD);
        dmem_req   = (state == S_MEMORY);
        halted     = (state == S_HALT) || (state == S_ERROR);
        busy       = (state != S_IDLE) && (state != S_HALT) && (state != S_ERROR);
    end

`ifdef SEQ_CTRL_PERF_EN
    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (busy)             cycle_cnt <= cycle_cnt + 32'd1;
            if (state == S_PCUPD) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: a stage-name reference model checked
// every cycle, directed scenarios with literal expectations, then random
// traffic.
module tb_seq_ctrl;

    localparam logic [63:0] TB_RESET_PC = 64'h0000_0000_0000_1000;
    localparam int          TB_TIMEOUT  = 15;
`ifdef SEQ_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        imem_error = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        dmem_error = 1'b0;
    logic [63:0] new_pc = 64'd0;
    logic [63:0] pc;
    logic        en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc;
    logic        dmem_req;
    logic [1:0]  stat;
    logic        halted, busy;
    logic [31:0] cycle_cnt, instr_cnt;
    logic [5:0]  en_vec;

    assign en_vec = {en_fetch, en_decode, en_execute, en_memory, en_wb, en_pc};

    always #5 clk = ~clk;

    seq_ctrl #(.RESET_PC(TB_RESET_PC), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
        .imem_error(imem_error), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .new_pc(new_pc), .pc(pc),
        .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute),
        .en_memory(en_memory), .en_wb(en_wb), .en_pc(en_pc),
        .dmem_req(dmem_req), .stat(stat), .halted(halted), .busy(busy),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (stage names, cycle-in-memory count)
    string       m_stage = "IDLE";
    logic [63:0] m_pc = TB_RESET_PC;
    logic [1:0]  m_stat = 2'b00;
    logic [3:0]  m_icode = 4'h0;
    int          m_mem = 0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ins = 32'd0;

    function automatic bit is_busy(input string s);
        return !(s == "IDLE" || s == "HALT" || s == "ERROR");
    endfunction

    function automatic bit is_mem_op(input logic [3:0] op);
        return op inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_stage = "IDLE"; m_pc = TB_RESET_PC; m_stat = 2'b00;
            m_mem = 0; m_cyc = 32'd0; m_ins = 32'd0;
            return;
        end
        if (PERF && is_busy(m_stage)) m_cyc = m_cyc + 32'd1;
        if (PERF && m_stage == "PCUPD") m_ins = m_ins + 32'd1;
        if (m_stage == "IDLE") begin
            if (start) m_stage = "FETCH";
        end else if (m_stage == "FETCH") begin
            m_icode = icode;
            if (imem_error)         begin m_stage = "ERROR"; m_stat = 2'b10; end
            else if (icode == 4'h0) begin m_stage = "HALT";  m_stat = 2'b01; end
            else if (icode > 4'hB)  begin m_stage = "ERROR"; m_stat = 2'b11; end
            else m_stage = "DECODE";
        end else if (m_stage == "DECODE") begin
            m_stage = "EXECUTE";
        end else if (m_stage == "EXECUTE") begin
            if (is_mem_op(m_icode)) begin m_stage = "MEMORY"; m_mem = 1; end
            else m_stage = "WB";
        end else if (m_stage == "MEMORY") begin
            if (dmem_ack) begin
                if (dmem_error) begin m_stage = "ERROR"; m_stat = 2'b10; end
                else m_stage = "WB";
            end else if (m_mem == TB_TIMEOUT + 1) begin
                m_stage = "ERROR"; m_stat = 2'b10;
            end else begin
                m_mem++;
            end
        end else if (m_stage == "WB") begin
            m_stage = "PCUPD";
        end else if (m_stage == "PCUPD") begin
            m_pc = new_pc;
            m_stage = "FETCH";
        end
    endtask

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("enables", 64'(en_vec),
                  64'({m_stage == "FETCH", m_stage == "DECODE", m_stage == "EXECUTE",
                       m_stage == "MEMORY", m_stage == "WB", m_stage == "PCUPD"}));
            check("dmem_req", 64'(dmem_req), 64'(m_stage == "MEMORY"));
            check("pc", pc, m_pc);
            check("stat", 64'(stat), 64'(m_stat));
            check("halted", 64'(halted), 64'(m_stage == "HALT" || m_stage == "ERROR"));
            check("busy", 64'(busy), 64'(is_busy(m_stage)));
            check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            check("instr_cnt", 64'(instr_cnt), 64'(m_ins));
        end
    end

    // ---------------- stimulus helpers
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_error = 1'b0;
        dmem_ack = 1'b0; dmem_error = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // Issue start with the given opcode; returns in FETCH.
    task automatic launch(input logic [3:0] op);
        icode = op; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Count MEMORY cycles, raising ack in cycle ack_at (0 = never).
    task automatic mem_wait(input int ack_at, output int cnt);
        cnt = 0;
        for (int k = 0; k < 40 && dmem_req; k++) begin
            cnt++;
            dmem_ack = (cnt == ack_at);
            cyc();
        end
        dmem_ack = 1'b0;
    endtask

    logic [5:0] a_exp [5] = '{6'b100000, 6'b010000, 6'b001000, 6'b000010, 6'b000001};

    initial begin
        int mem;
        do_reset();
        chk_en = 1'b1;
        check("reset_pc", pc, TB_RESET_PC);
        check("reset_en", 64'(en_vec), 64'd0);

        // Non-memory instruction: F,D,E,W,P then back to FETCH.
        new_pc = 64'd2;
        launch(4'h6);
        check("a_stage0", 64'(en_vec), 64'(a_exp[0]));
        for (int i = 1; i < 5; i++) begin
            cyc();
            check("a_stage", 64'(en_vec), 64'(a_exp[i]));
            check("a_no_dmem", 64'(dmem_req), 64'd0);
        end
        cyc();
        check("a_pc", pc, 64'd2);
        check("a_instr", 64'(instr_cnt), PERF ? 64'd1 : 64'd0);
        check("a_cycles", 64'(cycle_cnt), PERF ? 64'd5 : 64'd0);

        // Memory instruction acked in its 3rd MEMORY cycle.
        do_reset();
        launch(4'h5); cyc(); cyc(); cyc();
        mem_wait(3, mem);
        check("b_mem_len", 64'(mem), 64'd3);
        check("b_wb", 64'(en_vec), 64'b000010);
        cyc(); cyc();
        check("b_cycles", 64'(cycle_cnt), PERF ? 64'd8 : 64'd0);
        check("b_stat", 64'(stat), 64'd0);

        // Halt is absorbing and ignores start.
        do_reset();
        launch(4'h0); cyc();
        check("c_halted", 64'(halted), 64'd1);
        check("c_stat", 64'(stat), 64'd1);
        check("c_busy", 64'(busy), 64'd0);
        check("c_pc", pc, TB_RESET_PC);
        start = 1'b1; cyc(); start = 1'b0; cyc();
        check("c_still_halt", 64'({halted, stat, en_vec}), 64'b1_01_000000);

        // Memory timeout, then ack on the last allowed cycle.
        do_reset();
        launch(4'h4); cyc(); cyc(); cyc();
        mem_wait(0, mem);
        check("d_timeout_len", 64'(mem), 64'd16);
        check("d_stat", 64'(stat), 64'd2);
        check("d_dmem_req", 64'(dmem_req), 64'd0);
        check("d_halted", 64'(halted), 64'd1);
        do_reset();
        launch(4'h4); cyc(); cyc(); cyc();
        mem_wait(16, mem);
        check("d2_len", 64'(mem), 64'd16);
        check("d2_wb", 64'(en_wb), 64'd1);
        check("d2_stat", 64'(stat), 64'd0);

        // Illegal opcode and fetch fault priority.
        do_reset();
        launch(4'hC); cyc();
        check("e_ins", 64'(stat), 64'd3);
        do_reset();
        imem_error = 1'b1;
        launch(4'h0); cyc();
        imem_error = 1'b0;
        check("e_adr", 64'(stat), 64'd2);

        // Reset while in MEMORY after pc has moved.
        do_reset();
        new_pc = 64'hABC;
        launch(4'h6); cyc(); cyc(); cyc();
        icode = 4'h8;
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("f_in_mem", 64'(dmem_req), 64'd1);
        check("f_pc_moved", pc, 64'hABC);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check("f_en", 64'({en_vec, dmem_req}), 64'd0);
        check("f_pc", pc, TB_RESET_PC);
        check("f_cnt", 64'({cycle_cnt, instr_cnt}), 64'd0);
        launch(4'h6);
        check("f_restart", 64'(en_fetch), 64'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ((m_stage == "HALT" || m_stage == "ERROR") && $urandom_range(0, 7) == 0)
                rst_n = 1'b0;
            start      = ($urandom_range(0, 3) == 0);
            icode      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(1, 11));
            imem_error = ($urandom_range(0, 29) == 0);
            dmem_ack   = ($urandom_range(0, 4) == 0);
            dmem_error = ($urandom_range(0, 5) == 0);
            new_pc     = {$urandom, $urandom};
            cyc();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
